// File: rtl/ifid_skid_buffer.sv
// rtl/ifid_skid_buffer.sv - two-entry {pc, inst} elastic buffer between fetch and decode
module ifid_skid_buffer #(
    parameter int WIDTH = 32,
    parameter int PC_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PC_W-1:0]  in_pc,
    input  logic [WIDTH-1:0] in_inst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc,
    output logic [WIDTH-1:0] out_inst,
    output logic [1:0]       count
);

    // slot0 is the head seen by decode; slot1 is the skid entry that
    // catches the fetch that was already in flight when decode stalled
    logic [1:0]       cnt_q;
    logic [PC_W-1:0]  pc0_q;
    logic [WIDTH-1:0] inst0_q;
    logic [PC_W-1:0]  pc1_q;
    logic [WIDTH-1:0] inst1_q;

    logic push;
    logic pop;

    // ready and valid come only from registered occupancy, so there is no
    // combinational path from out_ready back to in_ready
    always_comb begin
        in_ready  = ~rst & (cnt_q != 2'd2);
        out_valid = (cnt_q != 2'd0);
        push      = in_valid & in_ready & ~flush;
        pop       = out_valid & out_ready & ~flush;
        out_pc    = pc0_q;
        out_inst  = inst0_q;
        count     = cnt_q;
    end

    // occupancy and slot update; rst beats flush, flush beats push/pop
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= 2'd0;
            pc0_q   <= '0;
            inst0_q <= '0;
            pc1_q   <= '0;
            inst1_q <= '0;
        end else if (flush) begin
            // slot contents are left as-is; they are don't-care once count is 0
            cnt_q <= 2'd0;
        end else begin
            case (cnt_q)
                2'd0: begin
                    if (push) begin
                        pc0_q   <= in_pc;
                        inst0_q <= in_inst;
                        cnt_q   <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        // head leaves and the new fetch takes its place directly
                        pc0_q   <= in_pc;
                        inst0_q <= in_inst;
                    end else if (push) begin
                        pc1_q   <= in_pc;
                        inst1_q <= in_inst;
                        cnt_q   <= 2'd2;
                    end else if (pop) begin
                        cnt_q <= 2'd0;
                    end
                end
                2'd2: begin
                    // full: in_ready is low, so only a pop can move the skid entry up
                    if (pop) begin
                        pc0_q   <= pc1_q;
                        inst0_q <= inst1_q;
                        cnt_q   <= 2'd1;
                    end
                end
                default: begin
                    cnt_q <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifid_skid_buffer.sv
// tb/tb_ifid_skid_buffer.sv - self-checking bench for ifid_skid_buffer
module tb_ifid_skid_buffer;

    localparam int WIDTH = 32;
    localparam int PC_W  = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [PC_W-1:0]  in_pc = '0;
    logic [WIDTH-1:0] in_inst = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [PC_W-1:0]  out_pc;
    logic [WIDTH-1:0] out_inst;
    logic [1:0]       count;

    int vectors = 0;
    int miscompares = 0;

    ifid_skid_buffer #(.WIDTH(WIDTH), .PC_W(PC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // one clock: drive inputs, let the edge happen, land 1 time unit after it
    task automatic cycle(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_inst   = pc ^ 32'h0000_0013;
        out_ready = rdy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    // reference model: a FIFO of {pc, inst} with capacity two
    logic [63:0] q[$];
    bit          started = 0;
    bit          zero_head = 0;

    // compare DUT with the model, then advance the model by the upcoming edge
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                chk("m_count", {62'd0, count}, 64'(q.size()));
                chk("m_out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
                chk("m_in_ready", {63'd0, in_ready}, {63'd0, (!rst) && q.size() < 2});
                if (q.size() != 0)
                    chk("m_head", {out_pc, out_inst}, q[0]);
                else if (zero_head)
                    chk("m_head_reset", {out_pc, out_inst}, 64'd0);
            end
            if (rst) begin
                q.delete();
                zero_head = 1;
                started = 1;
            end else if (started) begin
                if (flush) begin
                    q.delete();
                    zero_head = 0;
                end else begin
                    bit do_pop;
                    bit do_push;
                    do_pop  = (q.size() != 0) && out_ready;
                    do_push = in_valid && (q.size() < 2);
                    if (do_pop) void'(q.pop_front());
                    if (do_push) begin
                        q.push_back({in_pc, in_inst});
                        zero_head = 0;
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] pc;

        // 1: reset then idle
        rst = 1'b1;
        cycle(0, 32'h0, 0, 0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        cycle(0, 32'h0, 0, 0);
        rst = 1'b0;
        #1;
        chk("rst_count", {62'd0, count}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_pc", {32'd0, out_pc}, 64'd0);
        chk("rst_in_ready_after", {63'd0, in_ready}, 64'd1);
        cycle(0, 32'h0, 1, 0);

        // 2: streaming with decode never stalled
        for (int i = 0; i < 8; i++) begin
            pc = 32'hBFC0_0000 + 32'(4 * i);
            cycle(1, pc, 1, 0);
            chk("stream_pc", {32'd0, out_pc}, {32'd0, pc});
            chk("stream_count", {62'd0, count}, 64'd1);
        end
        cycle(0, 32'h0, 1, 0);
        chk("stream_drain", {63'd0, out_valid}, 64'd0);

        // 3: stall fills both slots, release drains in order
        cycle(1, 32'hBFC0_0000, 0, 0);
        cycle(1, 32'hBFC0_0004, 0, 0);
        chk("full_count", {62'd0, count}, 64'd2);
        chk("full_in_ready", {63'd0, in_ready}, 64'd0);
        chk("full_hold_pc", {32'd0, out_pc}, 64'hBFC0_0000);
        cycle(0, 32'h0, 0, 0);
        chk("stall_hold_pc", {32'd0, out_pc}, 64'hBFC0_0000);
        cycle(0, 32'h0, 1, 0);
        chk("drain_second_pc", {32'd0, out_pc}, 64'hBFC0_0004);
        chk("drain_count", {62'd0, count}, 64'd1);
        cycle(0, 32'h0, 1, 0);
        chk("drain_empty", {62'd0, count}, 64'd0);

        // 4: flush while full with a same-cycle fetch
        cycle(1, 32'hBFC0_0010, 0, 0);
        cycle(1, 32'hBFC0_0014, 0, 0);
        cycle(1, 32'hBFC0_0100, 1, 1);
        chk("flush_count", {62'd0, count}, 64'd0);
        chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
        cycle(0, 32'h0, 1, 0);
        chk("flush_no_emit", {63'd0, out_valid}, 64'd0);

        // 5: push and pop together at count 1
        cycle(1, 32'hBFC0_0200, 0, 0);
        cycle(1, 32'hBFC0_0204, 1, 0);
        chk("pushpop_count", {62'd0, count}, 64'd1);
        chk("pushpop_pc", {32'd0, out_pc}, 64'hBFC0_0204);
        chk("pushpop_inst", {32'd0, out_inst}, 64'hBFC0_0217);
        cycle(0, 32'h0, 1, 0);

        // 6: random traffic against the model
        for (int i = 0; i < 10000; i++) begin
            cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 31) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
